// File: rtl/uart_frame_ctrl_if.sv
// Bundle of the RX FIFO, TX FIFO, decoded-command and app-report signals around uart_frame_ctrl.
// The master modport is the frame controller; the slave modport is its environment.
interface uart_frame_ctrl_if;
  logic       rx_empty;
  logic [7:0] rx_pop_data;
  logic       rx_pop;
  logic       tx_full;
  logic       tx_push;
  logic [7:0] tx_push_data;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_data;
  logic       rx_err;
  logic       app_req;
  logic [7:0] app_cmd;
  logic [7:0] app_data;
  logic       app_grant;
  logic       app_done;
  logic       busy;

  modport master (
    input  rx_empty, rx_pop_data, tx_full, app_req, app_cmd, app_data,
    output rx_pop, tx_push, tx_push_data, cmd_valid, cmd_code, cmd_data, rx_err,
    output app_grant, app_done, busy
  );

  modport slave (
    output rx_empty, rx_pop_data, tx_full, app_req, app_cmd, app_data,
    input  rx_pop, tx_push, tx_push_data, cmd_valid, cmd_code, cmd_data, rx_err,
    input  app_grant, app_done, busy
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Frame layer over a byte UART: parses 4-byte RX command frames (SOF, CMD, DATA, CMD^DATA)
// and serialises ACK/NAK responses and app report frames into the TX FIFO without interleaving.
module uart_frame_ctrl #(
  parameter logic [7:0]  SOF_BYTE    = 8'hA5,
  parameter logic [7:0]  ACK_CMD     = 8'h06,
  parameter logic [7:0]  NAK_CMD     = 8'h15,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input logic              clk,
  input logic              reset,
  uart_frame_ctrl_if.master bus
);

  localparam int unsigned   TmoW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {RSof, RCmd, RData, RChk} rx_state_e;
  typedef enum logic [2:0] {TIdle, TSof, TCmd, TData, TChk} tx_state_e;

  rx_state_e       rx_q, rx_d;
  tx_state_e       tx_q, tx_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      sh_cmd_q, sh_cmd_d, sh_data_q, sh_data_d;
  logic            cmd_valid_q, cmd_valid_d, rx_err_q, rx_err_d;
  logic [7:0]      cmd_code_q, cmd_code_d, cmd_data_q, cmd_data_d;
  logic            rsp_pend_q, rsp_pend_d;
  logic [7:0]      rsp_cmd_q, rsp_cmd_d, rsp_data_q, rsp_data_d;
  logic [7:0]      f_cmd_q, f_cmd_d, f_data_q, f_data_d;
  logic            f_app_q, f_app_d;

  logic       consume;
  logic       rsp_set, rsp_take;
  logic [7:0] rsp_set_cmd;
  logic       tx_push, app_grant, app_done;
  logic [7:0] tx_push_data;

  assign consume = !bus.rx_empty;

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q        <= RSof;
      tx_q        <= TIdle;
      tmo_q       <= '0;
      sh_cmd_q    <= 8'h00;
      sh_data_q   <= 8'h00;
      cmd_valid_q <= 1'b0;
      rx_err_q    <= 1'b0;
      cmd_code_q  <= 8'h00;
      cmd_data_q  <= 8'h00;
      rsp_pend_q  <= 1'b0;
      rsp_cmd_q   <= 8'h00;
      rsp_data_q  <= 8'h00;
      f_cmd_q     <= 8'h00;
      f_data_q    <= 8'h00;
      f_app_q     <= 1'b0;
    end else begin
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      tmo_q       <= tmo_d;
      sh_cmd_q    <= sh_cmd_d;
      sh_data_q   <= sh_data_d;
      cmd_valid_q <= cmd_valid_d;
      rx_err_q    <= rx_err_d;
      cmd_code_q  <= cmd_code_d;
      cmd_data_q  <= cmd_data_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_cmd_q   <= rsp_cmd_d;
      rsp_data_q  <= rsp_data_d;
      f_cmd_q     <= f_cmd_d;
      f_data_q    <= f_data_d;
      f_app_q     <= f_app_d;
    end
  end

  // RX next state, timeout and shadow/command registers
  always_comb begin
    rx_d        = rx_q;
    tmo_d       = tmo_q;
    sh_cmd_d    = sh_cmd_q;
    sh_data_d   = sh_data_q;
    cmd_valid_d = 1'b0;
    rx_err_d    = 1'b0;
    cmd_code_d  = cmd_code_q;
    cmd_data_d  = cmd_data_q;
    rsp_set     = 1'b0;
    rsp_set_cmd = ACK_CMD;

    if (rx_q == RSof || consume) begin
      tmo_d = '0;
    end else if (tmo_q == TmoLast) begin
      // Inter-byte gap too long: drop the partial frame, no response
      tmo_d    = '0;
      rx_d     = RSof;
      rx_err_d = 1'b1;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end

    if (consume) begin
      unique case (rx_q)
        RSof:  if (bus.rx_pop_data == SOF_BYTE) rx_d = RCmd;
        RCmd: begin
          sh_cmd_d = bus.rx_pop_data;
          rx_d     = RData;
        end
        RData: begin
          sh_data_d = bus.rx_pop_data;
          rx_d      = RChk;
        end
        RChk: begin
          rx_d    = RSof;
          rsp_set = 1'b1;
          if (bus.rx_pop_data == (sh_cmd_q ^ sh_data_q)) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = sh_cmd_q;
            cmd_data_d  = sh_data_q;
          end else begin
            rx_err_d    = 1'b1;
            rsp_set_cmd = NAK_CMD;
          end
        end
        default: rx_d = RSof;
      endcase
    end
  end

  // Single-entry response slot; a fresh response beats the take in the same cycle
  assign rsp_take = (tx_q == TIdle) && rsp_pend_q;

  always_comb begin
    rsp_pend_d = rsp_pend_q;
    rsp_cmd_d  = rsp_cmd_q;
    rsp_data_d = rsp_data_q;
    if (rsp_set) begin
      rsp_pend_d = 1'b1;
      rsp_cmd_d  = rsp_set_cmd;
      rsp_data_d = sh_cmd_q;
    end else if (rsp_take) begin
      rsp_pend_d = 1'b0;
    end
  end

  // TX next state and frame capture
  always_comb begin
    tx_d     = tx_q;
    f_cmd_d  = f_cmd_q;
    f_data_d = f_data_q;
    f_app_d  = f_app_q;
    unique case (tx_q)
      TIdle: begin
        if (rsp_pend_q) begin
          tx_d     = TSof;
          f_cmd_d  = rsp_cmd_q;
          f_data_d = rsp_data_q;
          f_app_d  = 1'b0;
        end else if (bus.app_req) begin
          tx_d     = TSof;
          f_cmd_d  = bus.app_cmd;
          f_data_d = bus.app_data;
          f_app_d  = 1'b1;
        end
      end
      TSof:    if (!bus.tx_full) tx_d = TCmd;
      TCmd:    if (!bus.tx_full) tx_d = TData;
      TData:   if (!bus.tx_full) tx_d = TChk;
      TChk:    if (!bus.tx_full) tx_d = TIdle;
      default: tx_d = TIdle;
    endcase
  end

  // TX outputs
  always_comb begin
    tx_push      = 1'b0;
    tx_push_data = 8'h00;
    app_grant    = 1'b0;
    app_done     = 1'b0;
    unique case (tx_q)
      TIdle: app_grant = !rsp_pend_q && bus.app_req;
      TSof: begin
        tx_push      = !bus.tx_full;
        tx_push_data = SOF_BYTE;
      end
      TCmd: begin
        tx_push      = !bus.tx_full;
        tx_push_data = f_cmd_q;
      end
      TData: begin
        tx_push      = !bus.tx_full;
        tx_push_data = f_data_q;
      end
      TChk: begin
        tx_push      = !bus.tx_full;
        tx_push_data = f_cmd_q ^ f_data_q;
        app_done     = f_app_q && !bus.tx_full;
      end
      default: ;
    endcase
  end

  assign bus.rx_pop       = consume;
  assign bus.tx_push      = tx_push;
  assign bus.tx_push_data = tx_push_data;
  assign bus.app_grant    = app_grant;
  assign bus.app_done     = app_done;
  assign bus.busy         = (tx_q != TIdle);
  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.cmd_code     = cmd_code_q;
  assign bus.cmd_data     = cmd_data_q;
  assign bus.rx_err       = rx_err_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: RX frames in, decoded commands and TX byte stream checked
// against hand-computed frames.
module tb_uart_frame_ctrl;
  localparam int unsigned Tmo = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_frame_ctrl_if bus_if ();

  uart_frame_ctrl #(
    .SOF_BYTE    (8'hA5),
    .ACK_CMD     (8'h06),
    .NAK_CMD     (8'h15),
    .TIMEOUT_CYC (Tmo)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every pushed byte and every pulse, sampled mid-cycle
  logic [7:0] push_data[$];
  int         push_cyc[$];
  int         n_valid = 0, n_err = 0, n_grant = 0, n_done = 0;
  int         err_cyc = -1, grant_cyc = -1, done_cyc = -1;

  always @(negedge clk) begin
    if (bus_if.tx_push) begin
      push_data.push_back(bus_if.tx_push_data);
      push_cyc.push_back(cyc);
    end
    if (bus_if.cmd_valid) n_valid++;
    if (bus_if.rx_err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (bus_if.app_grant) begin
      n_grant++;
      grant_cyc = cyc;
    end
    if (bus_if.app_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  int n_vec  = 0;
  int n_miss = 0;
  int t_last = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_byte(input int i);
    if (i < push_data.size()) return 32'(push_data[i]);
    return 32'hDEAD;
  endfunction

  function automatic int log_cyc(input int i);
    if (i < push_cyc.size()) return push_cyc[i];
    return -1000;
  endfunction

  task automatic check_tx(input string tag, input int base,
                          input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e[4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_b%0d", tag, i), log_byte(base + i), 32'(e[i]));
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_empty    = 1'b0;
    bus_if.rx_pop_data = b;
    @(posedge clk);
    #1;
    bus_if.rx_empty = 1'b1;
    t_last = cyc;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int  bp, bv, be, bg, bd;
  bit  seen;

  task automatic snap();
    bp = push_data.size();
    bv = n_valid;
    be = n_err;
    bg = n_grant;
    bd = n_done;
  endtask

  initial begin
    reset              = 1'b1;
    bus_if.rx_empty    = 1'b1;
    bus_if.rx_pop_data = 8'h00;
    bus_if.tx_full     = 1'b0;
    bus_if.app_req     = 1'b0;
    bus_if.app_cmd     = 8'h00;
    bus_if.app_data    = 8'h00;
    idle(3);

    check_eq("rst_busy",      32'(bus_if.busy),      32'h0);
    check_eq("rst_cmd_valid", 32'(bus_if.cmd_valid), 32'h0);
    check_eq("rst_cmd_code",  32'(bus_if.cmd_code),  32'h0);
    check_eq("rst_cmd_data",  32'(bus_if.cmd_data),  32'h0);
    check_eq("rst_rx_err",    32'(bus_if.rx_err),    32'h0);
    check_eq("rst_tx_push",   32'(bus_if.tx_push),   32'h0);
    check_eq("rst_app_grant", 32'(bus_if.app_grant), 32'h0);
    reset = 1'b0;
    idle(2);

    // Good frame -> command + ACK on four back-to-back cycles
    snap();
    send_frame(8'hA5, 8'h10, 8'h3C, 8'h2C);
    idle(10);
    check_eq("good_valid_cnt", 32'(n_valid - bv), 32'd1);
    check_eq("good_err_cnt",   32'(n_err - be),   32'd0);
    check_eq("good_code",      32'(bus_if.cmd_code), 32'h10);
    check_eq("good_data",      32'(bus_if.cmd_data), 32'h3C);
    check_eq("good_push_cnt",  32'(push_data.size() - bp), 32'd4);
    check_tx("good_ack", bp, 8'hA5, 8'h06, 8'h10, 8'h16);
    check_eq("good_ack_span",  32'(log_cyc(bp + 3) - log_cyc(bp)), 32'd3);

    // Bad checksum -> rx_err + NAK, command regs unchanged
    snap();
    send_frame(8'hA5, 8'h10, 8'h3C, 8'hFF);
    idle(10);
    check_eq("bad_err_cnt",   32'(n_err - be),   32'd1);
    check_eq("bad_valid_cnt", 32'(n_valid - bv), 32'd0);
    check_eq("bad_code",      32'(bus_if.cmd_code), 32'h10);
    check_eq("bad_data",      32'(bus_if.cmd_data), 32'h3C);
    check_eq("bad_push_cnt",  32'(push_data.size() - bp), 32'd4);
    check_tx("bad_nak", bp, 8'hA5, 8'h15, 8'h10, 8'h05);

    // Leading garbage discarded
    snap();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'hA5, 8'h22, 8'h01, 8'h23);
    idle(10);
    check_eq("garb_valid_cnt", 32'(n_valid - bv), 32'd1);
    check_eq("garb_err_cnt",   32'(n_err - be),   32'd0);
    check_eq("garb_code",      32'(bus_if.cmd_code), 32'h22);
    check_eq("garb_data",      32'(bus_if.cmd_data), 32'h01);
    check_tx("garb_ack", bp, 8'hA5, 8'h06, 8'h22, 8'h24);

    // Inter-byte timeout after A5,10 -> single rx_err, no response, then recovery
    snap();
    send_byte(8'hA5);
    send_byte(8'h10);
    idle(Tmo + 14);
    check_eq("tmo_err_cnt",  32'(n_err - be), 32'd1);
    check_eq("tmo_err_cyc",  32'(err_cyc), 32'(t_last + int'(Tmo)));
    check_eq("tmo_push_cnt", 32'(push_data.size() - bp), 32'd0);
    send_frame(8'hA5, 8'h01, 8'h02, 8'h03);
    idle(10);
    check_eq("tmo_rec_valid", 32'(n_valid - bv), 32'd1);
    check_eq("tmo_rec_code",  32'(bus_if.cmd_code), 32'h01);
    check_eq("tmo_rec_data",  32'(bus_if.cmd_data), 32'h02);
    check_eq("tmo_rec_push",  32'(push_data.size() - bp), 32'd4);
    check_tx("tmo_rec_ack", bp, 8'hA5, 8'h06, 8'h01, 8'h07);

    // app_req raised as the ACK becomes pending: ACK frame first, then app frame
    snap();
    send_frame(8'hA5, 8'h10, 8'h3C, 8'h2C);
    bus_if.app_req  = 1'b1;
    bus_if.app_cmd  = 8'h40;
    bus_if.app_data = 8'h07;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.app_grant) seen = 1'b1;
    end
    check_eq("app_grant_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    bus_if.app_req  = 1'b0;
    bus_if.app_cmd  = 8'hEE;
    bus_if.app_data = 8'hEE;
    idle(12);
    check_eq("app_push_cnt",  32'(push_data.size() - bp), 32'd8);
    check_tx("app_ack",   bp,     8'hA5, 8'h06, 8'h10, 8'h16);
    check_tx("app_frame", bp + 4, 8'hA5, 8'h40, 8'h07, 8'h47);
    check_eq("app_grant_cnt", 32'(n_grant - bg), 32'd1);
    check_eq("app_grant_cyc", 32'(grant_cyc), 32'(log_cyc(bp + 3) + 1));
    check_eq("app_done_cnt",  32'(n_done - bd), 32'd1);
    check_eq("app_done_cyc",  32'(done_cyc), 32'(log_cyc(bp + 7)));

    // tx_full for 5 cycles while in T_DATA
    snap();
    send_frame(8'hA5, 8'h10, 8'h3C, 8'h2C);
    idle(3);
    bus_if.tx_full = 1'b1;
    @(negedge clk);
    check_eq("full_busy", 32'(bus_if.busy),    32'd1);
    check_eq("full_push", 32'(bus_if.tx_push), 32'd0);
    idle(5);
    bus_if.tx_full = 1'b0;
    idle(8);
    check_eq("full_push_cnt", 32'(push_data.size() - bp), 32'd4);
    check_tx("full_ack", bp, 8'hA5, 8'h06, 8'h10, 8'h16);
    check_eq("full_stall_gap", 32'(log_cyc(bp + 2) - log_cyc(bp + 1)), 32'd6);
    check_eq("full_chk_gap",   32'(log_cyc(bp + 3) - log_cyc(bp + 2)), 32'd1);

    // Reset while in T_CMD
    snap();
    send_frame(8'hA5, 8'h10, 8'h3C, 8'h2C);
    idle(2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_busy", 32'(bus_if.busy), 32'd0);
    idle(10);
    check_eq("rst_mid_push_cnt", 32'(push_data.size() - bp), 32'd2);
    check_eq("rst_mid_code",     32'(bus_if.cmd_code), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Framing controller that sits between the game logic and the byte-level UART controller (RX/TX FIFOs, baud gen).
- RX path: drains the RX FIFO, parses fixed 4-byte command frames, checks them, and hands decoded commands to the game logic.
- TX path: arbitrates the TX FIFO between automatic ACK/NAK responses and application report frames, so frames never interleave.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame marker for both directions
ACK_CMD, 8'h06, command byte of ACK response
NAK_CMD, 8'h15, command byte of NAK response
TIMEOUT_CYC, 1_000_000, max cycles between consecutive bytes of one RX frame (10 ms at 100 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
rx_empty  in  1  RX FIFO empty
rx_pop_data  in  8  RX FIFO head byte, show-ahead, valid while rx_empty=0
rx_pop  out  1  one-cycle pop of RX FIFO head
tx_full  in  1  TX FIFO full
tx_push  out  1  one-cycle push to TX FIFO
tx_push_data  out  8  byte pushed with tx_push
cmd_valid  out  1  one-cycle pulse, good frame received
cmd_code  out  8  received CMD, held until next cmd_valid
cmd_data  out  8  received DATA, held until next cmd_valid
rx_err  out  1  one-cycle pulse on checksum error or timeout
app_req  in  1  level request to send a report frame
app_cmd  in  8  report CMD, stable while app_req=1
app_data  in  8  report DATA, stable while app_req=1
app_grant  out  1  one-cycle pulse when app_cmd/app_data are captured
app_done  out  1  one-cycle pulse when last byte of app frame is pushed
busy  out  1  TX sequencer not idle

Behaviour:
- Frame format, both directions: SOF_BYTE, CMD, DATA, CHK, where CHK = CMD ^ DATA.
- Reset values: all outputs 0, cmd_code/cmd_data 8'h00, both FSMs in their idle state, ack pending flag cleared, timeout counter 0.

RX FSM (R_SOF, R_CMD, R_DATA, R_CHK):
- Pop rule: in every state, rx_pop = !rx_empty. At most one byte is consumed per cycle; the byte consumed is rx_pop_data in the same cycle.
- R_SOF: non-SOF bytes are discarded silently. On SOF_BYTE go to R_CMD.
- R_CMD: latch the byte into a shadow register, go to R_DATA. A byte equal to SOF_BYTE is treated as data.
- R_DATA: latch the byte, go to R_CHK.
- R_CHK, byte == CMD^DATA: next cycle cmd_valid=1 and cmd_code/cmd_data update from the shadows; queue ACK with data=CMD. Return to R_SOF.
- R_CHK, checksum mismatch: next cycle rx_err=1; queue NAK with data=CMD; cmd_code/cmd_data unchanged. Return to R_SOF.
- Timeout counter: cleared on every consumed byte and in R_SOF. Counts while in R_CMD/R_DATA/R_CHK with rx_empty=1. On reaching TIMEOUT_CYC-1: rx_err pulse, go to R_SOF, no response queued.
- Response slot: single entry. A new response while one is still pending (not yet granted) overwrites it; the latest response wins.

TX FSM (T_IDLE, T_SOF, T_CMD, T_DATA, T_CHK):
- T_IDLE arbitration (fixed priority): pending ACK/NAK over app_req. An arbitration decision is made only in T_IDLE, so a frame in progress is never preempted.
- On selecting a source: latch its cmd/data into frame registers and go to T_SOF. When the source is the app, app_grant pulses in that same cycle.
- A pending response is cleared in the cycle it is selected. A response arriving in that same cycle still sets the slot (set wins).
- T_SOF..T_CHK: in each state, if tx_full=0, assert tx_push with SOF, CMD, DATA, CHK respectively and advance. If tx_full=1, hold the state with tx_push=0 and no byte is lost.
- Leaving T_CHK: return to T_IDLE. For app frames, app_done pulses in the same cycle as the CHK push.
- Throughput: minimum 4 cycles per frame, plus 1 idle arbitration cycle between frames.
- busy=1 in every state except T_IDLE.
- app_req may be dropped at any time before app_grant and is then ignored. After app_grant, app_cmd/app_data may change freely.

Reset mid-operation: both FSMs return to idle in the next cycle. Any partial RX frame is dropped, any partial TX frame is abandoned (bytes already pushed stay in the FIFO), and the pending response is cleared.

Test Plan:
- RX bytes A5,10,3C,2C, TX never full -> cmd_valid once with cmd_code=10, cmd_data=3C; TX pushes A5,06,10,16 on 4 consecutive cycles.
- RX A5,10,3C,FF -> rx_err pulse, cmd_code unchanged; TX pushes A5,15,10,05.
- Garbage 00,FF then A5,22,01,23 -> garbage discarded; cmd_valid with 22/01 and ACK frame A5,06,22,24.
- RX A5,10 then idle TIMEOUT_CYC cycles -> rx_err exactly once; next A5,01,02,03 is accepted normally.
- app_req with 40/07 raised in the same cycle a response becomes pending -> ACK frame sent first, then app_grant, then A5,40,07,47 with app_done on the last push.
- tx_full held high for 5 cycles during T_DATA -> tx_push low, state held; after release the remaining bytes DATA,CHK are pushed in order with no duplicates; reset asserted in T_CMD -> busy=0 the next cycle.
